corescore_stream_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-Stream byte sink (the UART emitter) between N independent byte-stream producers (e.g. the core-count report, a status/heartbeat source, a debug dump). A packet is held until its `tlast` beat is accepted, so frames from different producers never interleave on the UART. The block sits between the producers and `emitter_uart`. The output side is a registered, full-throughput skid stage, so the emitter sees registered `tvalid`/`tdata`/`tlast`.

---
 rtl/corescore_stream_arbiter_pkg.sv | 32 +++
 rtl/corescore_stream_arbiter_if.sv | 27 ++
 rtl/corescore_stream_arbiter_axis_skid_buffer.sv | 82 ++++++++
 rtl/corescore_stream_arbiter.sv | 105 ++++++++++
 tb/tb_corescore_stream_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/corescore_stream_arbiter_pkg.sv
// Shared definitions for the corescore stream blocks: FSM encoding, default
// data width and the round-robin winner picker.
package corescore_stream_pkg;

   localparam int DEFAULT_W = 8;
   localparam int MAX_N     = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // One-hot winner: first set bit of req at or after ptr, wrapping at n.
   function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                input logic [3:0]       ptr,
                                                input int               n);
      logic [MAX_N-1:0] win;
      logic             found;
      logic [3:0]       idx;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_N; i++) begin
         idx = 4'((int'(ptr) + i) % n);
         if ((i < n) && !found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/corescore_stream_arbiter_if.sv
// Handshake bundle between N byte producers, the arbiter and the UART sink.
interface corescore_stream_arbiter_if
   import corescore_stream_pkg::*;
#(
   parameter int N = 4,
   parameter int W = DEFAULT_W
);
   logic [N*W-1:0] i_tdata;
   logic [N-1:0]   i_tlast;
   logic [N-1:0]   i_tvalid;
   logic [N-1:0]   o_tready;
   logic [W-1:0]   o_tdata;
   logic           o_tlast;
   logic           o_tvalid;
   logic           i_tready;
   logic [N-1:0]   o_grant;

   modport slave (
      input  i_tdata, i_tlast, i_tvalid, i_tready,
      output o_tready, o_tdata, o_tlast, o_tvalid, o_grant
   );

   modport master (
      output i_tdata, i_tlast, i_tvalid, i_tready,
      input  o_tready, o_tdata, o_tlast, o_tvalid, o_grant
   );
endinterface

// File: rtl/corescore_stream_arbiter_axis_skid_buffer.sv
// Two-entry registered AXI-Stream stage: full throughput, registered outputs,
// upstream ready driven only from the registered skid occupancy.
module axis_skid_buffer
   import corescore_stream_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_tdata,
   input  logic         i_tlast,
   input  logic         i_tvalid,
   output logic         o_tready,
   output logic [W-1:0] o_tdata,
   output logic         o_tlast,
   output logic         o_tvalid,
   input  logic         i_tready
);

   logic [W-1:0] main_data_q, main_data_d;
   logic         main_last_q, main_last_d;
   logic         main_vld_q,  main_vld_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         skid_last_q, skid_last_d;
   logic         skid_full_q, skid_full_d;
   logic         accept;
   logic         main_free;

   always_comb begin
      main_data_d = main_data_q;
      main_last_d = main_last_q;
      main_vld_d  = main_vld_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      skid_full_d = skid_full_q;
      accept      = i_tvalid & ~skid_full_q;
      main_free   = ~main_vld_q | i_tready;
      if (main_free) begin
         // Skid holds the older beat, so it always drains first.
         if (skid_full_q) begin
            main_data_d = skid_data_q;
            main_last_d = skid_last_q;
            main_vld_d  = 1'b1;
            skid_full_d = 1'b0;
         end else if (accept) begin
            main_data_d = i_tdata;
            main_last_d = i_tlast;
            main_vld_d  = 1'b1;
         end else begin
            main_vld_d  = 1'b0;
         end
      end else if (accept) begin
         skid_data_d = i_tdata;
         skid_last_d = i_tlast;
         skid_full_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         main_data_q <= '0;
         main_last_q <= 1'b0;
         main_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
         skid_full_q <= 1'b0;
      end else begin
         main_data_q <= main_data_d;
         main_last_q <= main_last_d;
         main_vld_q  <= main_vld_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
         skid_full_q <= skid_full_d;
      end
   end

   assign o_tready = ~skid_full_q;
   assign o_tdata  = main_data_q;
   assign o_tlast  = main_last_q;
   assign o_tvalid = main_vld_q;

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-level round-robin arbiter: N byte-stream producers share one
// AXI-Stream sink; a grant is held until the owner's tlast beat is accepted.
module corescore_stream_arbiter
   import corescore_stream_pkg::*;
#(
   parameter int N = 4,
   parameter int W = DEFAULT_W
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   corescore_stream_arbiter_if.slave   bus
);

   arb_state_e       state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [3:0]       rr_ptr_q, rr_ptr_d;
   logic [MAX_N-1:0] pick;
   logic [N-1:0]     win;
   logic [3:0]       win_idx;
   logic [W-1:0]     sel_data;
   logic             sel_last;
   logic             sel_valid;
   logic             skid_ready;
   logic             xfer;

   always_comb begin
      pick    = rr_pick(MAX_N'(bus.i_tvalid), rr_ptr_q, N);
      win     = pick[N-1:0];
      win_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (win[k]) win_idx = 4'(k);
      end
   end

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (grant_q[k]) begin
            sel_data = bus.i_tdata[k*W +: W];
            sel_last = bus.i_tlast[k];
         end
      end
      sel_valid = |(bus.i_tvalid & grant_q);
      xfer      = sel_valid & skid_ready;
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (|bus.i_tvalid) begin
               grant_d  = win;
               rr_ptr_d = (win_idx == 4'(N-1)) ? 4'd0 : win_idx + 4'd1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            // Owner stays locked through tvalid gaps; only tlast releases it.
            if (xfer && sel_last) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // grant_q is cleared in IDLE, so it doubles as the status output and ready mask.
   assign bus.o_grant  = grant_q;
   assign bus.o_tready = grant_q & {N{skid_ready}};

   axis_skid_buffer #(
      .W (W)
   ) u_skid (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_tdata  (sel_data),
      .i_tlast  (sel_last),
      .i_tvalid (sel_valid),
      .o_tready (skid_ready),
      .o_tdata  (bus.o_tdata),
      .o_tlast  (bus.o_tlast),
      .o_tvalid (bus.o_tvalid),
      .i_tready (bus.i_tready)
   );

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Directed bench for corescore_stream_arbiter (N=4, W=8) with per-cycle
// protocol checks and hand-derived packet/grant expectations.
module tb_corescore_stream_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   corescore_stream_arbiter_if #(.N(4), .W(8)) bus ();

   corescore_stream_arbiter #(.N(4), .W(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [8:0] src_mem [4][128];
   int         src_rd [4];
   int         src_wr [4];
   logic [8:0] out_mem [256];
   int         out_cyc [256];
   int         out_n = 0;
   logic [3:0] gnt_log [64];
   int         gnt_cyc [64];
   int         gnt_n = 0;
   logic [3:0] prev_gnt = 4'd0;
   logic       hold_prev = 1'b0;
   logic [8:0] hold_val = 9'd0;
   int         acc_n = 0;
   int         emit_n = 0;
   int         cyc = 0;
   bit         rdy_rand = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int k, input logic [8:0] beat);
      src_mem[k][src_wr[k]] = beat;
      src_wr[k]++;
   endtask

   task automatic present();
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      v = 4'd0;
      l = 4'd0;
      d = 32'd0;
      for (int k = 0; k < 4; k++) begin
         if (src_rd[k] < src_wr[k]) begin
            v[k]         = 1'b1;
            d[k*8 +: 8]  = src_mem[k][src_rd[k]][7:0];
            l[k]         = src_mem[k][src_rd[k]][8];
         end
      end
      bus.i_tvalid = v;
      bus.i_tdata  = d;
      bus.i_tlast  = l;
   endtask

   // One clock: sample and check at the falling edge, advance sources after the rising edge.
   task automatic cycle();
      logic [3:0] hs;
      int         infl;
      @(negedge clk);
      hs   = bus.i_tvalid & bus.o_tready;
      infl = acc_n - emit_n;
      chk("tready_model", 32'(bus.o_tready),
          (bus.o_grant != 4'd0 && infl < 2) ? 32'(bus.o_grant) : 32'd0);
      chk("tvalid_occupancy", 32'(bus.o_tvalid), 32'(infl > 0));
      chk("grant_onehot0", 32'($onehot0(bus.o_grant)), 32'd1);
      if (hold_prev) begin
         chk("hold_tvalid", 32'(bus.o_tvalid), 32'd1);
         chk("hold_payload", 32'({bus.o_tlast, bus.o_tdata}), 32'(hold_val));
      end
      if (bus.o_grant != 4'd0 && prev_gnt == 4'd0) begin
         gnt_log[gnt_n] = bus.o_grant;
         gnt_cyc[gnt_n] = cyc;
         gnt_n++;
      end
      prev_gnt = bus.o_grant;
      if (bus.o_tvalid && bus.i_tready) begin
         out_mem[out_n] = {bus.o_tlast, bus.o_tdata};
         out_cyc[out_n] = cyc;
         out_n++;
         emit_n++;
      end
      hold_prev = bus.o_tvalid && !bus.i_tready;
      hold_val  = {bus.o_tlast, bus.o_tdata};
      if (hs != 4'd0) acc_n++;
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < 4; k++) begin
         if (hs[k]) src_rd[k]++;
      end
      present();
      bus.i_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic drain(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (out_n < target && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, 32'(out_n), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int o0, g0, L, base, n;

      for (int k = 0; k < 4; k++) begin
         src_rd[k] = 0;
         src_wr[k] = 0;
      end

      // Reset with random inputs
      rst_n        = 1'b0;
      bus.i_tvalid = 4'($urandom);
      bus.i_tdata  = $urandom;
      bus.i_tlast  = 4'($urandom);
      bus.i_tready = 1'($urandom);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_tvalid", 32'(bus.o_tvalid), 32'd0);
      chk("rst_tlast",  32'(bus.o_tlast),  32'd0);
      chk("rst_tdata",  32'(bus.o_tdata),  32'd0);
      chk("rst_tready", 32'(bus.o_tready), 32'd0);
      chk("rst_grant",  32'(bus.o_grant),  32'd0);
      @(posedge clk);
      #1;
      present();
      bus.i_tready = 1'b1;
      rst_n        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("idle_grant", 32'(bus.o_grant), 32'd0);
      end

      // Fairness: two 3-byte packets per requester, all valid together
      o0 = out_n;
      g0 = gnt_n;
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 4; k++)
            for (int i = 0; i < 3; i++)
               load(k, {(i == 2), 8'(k*16 + p*4 + i)});
      L = cyc;
      present();
      drain(o0 + 24, 200, "fair_count");
      chk("fair_grants", 32'(gnt_n - g0), 32'd8);
      for (int j = 0; j < 8; j++) begin
         chk("fair_grant_order", 32'(gnt_log[g0+j]), 32'(4'b0001 << (j % 4)));
         chk("fair_grant_cycle", 32'(gnt_cyc[g0+j]), 32'(L + 1 + 4*j));
      end
      chk("fair_first_latency", 32'(out_cyc[o0]), 32'(L + 2));
      for (int j = 0; j < 24; j++) begin
         chk("fair_beat", 32'(out_mem[o0+j]),
             32'({(j % 3 == 2), 8'(((j/3) % 4)*16 + (j/12)*4 + (j % 3))}));
         if (j > 0)
            chk("fair_spacing", 32'(out_cyc[o0+j] - out_cyc[o0+j-1]), (j % 3 == 0) ? 32'd2 : 32'd1);
      end

      // Single-beat packets from requesters 1 and 3
      o0 = out_n;
      g0 = gnt_n;
      load(1, 9'h111);
      load(3, 9'h133);
      present();
      drain(o0 + 2, 50, "single_count");
      chk("single_beat0", 32'(out_mem[o0]),   32'h111);
      chk("single_beat1", 32'(out_mem[o0+1]), 32'h133);
      chk("single_grant0", 32'(gnt_log[g0]),   32'h2);
      chk("single_grant1", 32'(gnt_log[g0+1]), 32'h8);
      chk("single_grant_gap", 32'(gnt_cyc[g0+1] - gnt_cyc[g0]), 32'd2);

      // Lock under tvalid gap: requester 2 holds the grant while requester 0 waits
      o0 = out_n;
      g0 = gnt_n;
      load(2, 9'h0A1);
      present();
      n = 0;
      while (src_rd[2] < src_wr[2] && n < 20) begin
         cycle();
         n++;
      end
      chk("lock_first_accept", 32'(src_rd[2]), 32'(src_wr[2]));
      load(0, 9'h0B1);
      load(0, 9'h1B2);
      present();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("lock_hold_grant", 32'(bus.o_grant), 32'h4);
      end
      load(2, 9'h0A2);
      load(2, 9'h1A3);
      present();
      drain(o0 + 5, 50, "lock_count");
      chk("lock_beat0", 32'(out_mem[o0]),   32'h0A1);
      chk("lock_beat1", 32'(out_mem[o0+1]), 32'h0A2);
      chk("lock_beat2", 32'(out_mem[o0+2]), 32'h1A3);
      chk("lock_beat3", 32'(out_mem[o0+3]), 32'h0B1);
      chk("lock_beat4", 32'(out_mem[o0+4]), 32'h1B2);
      chk("lock_grant0", 32'(gnt_log[g0]),   32'h4);
      chk("lock_grant1", 32'(gnt_log[g0+1]), 32'h1);

      // Backpressure: 64-byte packet from requester 1 with random sink ready
      o0 = out_n;
      g0 = gnt_n;
      for (int i = 0; i < 64; i++) load(1, {(i == 63), 8'(i*7 + 3)});
      present();
      rdy_rand = 1'b1;
      drain(o0 + 64, 1000, "bp_count");
      rdy_rand = 1'b0;
      cycle();
      cycle();
      chk("bp_no_extra", 32'(out_n), 32'(o0 + 64));
      chk("bp_grants", 32'(gnt_n - g0), 32'd1);
      chk("bp_grant", 32'(gnt_log[g0]), 32'h2);
      for (int i = 0; i < 64; i++)
         chk("bp_beat", 32'(out_mem[o0+i]), 32'({(i == 63), 8'(i*7 + 3)}));

      // Mid-packet reset: requester 2 sends 4 bytes, reset after the second
      base = src_rd[2];
      for (int i = 0; i < 4; i++) load(2, {(i == 3), 8'(8'hC1 + i)});
      present();
      n = 0;
      while (src_rd[2] < base + 2 && n < 20) begin
         cycle();
         n++;
      end
      chk("mid_two_accepted", 32'(src_rd[2]), 32'(base + 2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 32'(bus.o_tvalid), 32'd0);
      chk("mid_rst_tlast",  32'(bus.o_tlast),  32'd0);
      chk("mid_rst_tdata",  32'(bus.o_tdata),  32'd0);
      chk("mid_rst_tready", 32'(bus.o_tready), 32'd0);
      chk("mid_rst_grant",  32'(bus.o_grant),  32'd0);
      for (int k = 0; k < 4; k++) src_rd[k] = src_wr[k];
      present();
      acc_n     = 0;
      emit_n    = 0;
      hold_prev = 1'b0;
      prev_gnt  = 4'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      o0 = out_n;
      g0 = gnt_n;
      load(1, 9'h1D1);
      load(3, 9'h1E1);
      L = cyc;
      present();
      drain(o0 + 2, 50, "post_rst_count");
      chk("post_rst_grant0", 32'(gnt_log[g0]), 32'h2);
      chk("post_rst_grant_cycle", 32'(gnt_cyc[g0]), 32'(L + 1));
      chk("post_rst_grant1", 32'(gnt_log[g0+1]), 32'h8);
      chk("post_rst_beat0", 32'(out_mem[o0]),   32'h1D1);
      chk("post_rst_beat1", 32'(out_mem[o0+1]), 32'h1E1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
